dcache_uncached_responder: RTL and testbench

- Responder end of the execute-stage data-cache request interface: accepts one load/store per handshake from the ALUs, performs it as a single-word uncached bus transfer, returns completion to the mem stage.
- Sits between execute/mem and the cache-to-AXI bridge.
- Used as the bring-up data-cache replacement and as the uncached-access path.

---
 rtl/dcache_uncached_responder.sv | 174 +++++++++++++++++
 tb/tb_dcache_uncached_responder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_uncached_responder.sv
// -----------------------------------------------------------------------------
// dcache_uncached_responder
//
// Responder end of the execute-stage data-cache request interface. It takes
// one load/store per handshake and performs it as a single-word uncached bus
// transfer toward the cache-to-AXI bridge. Completion goes back to the mem
// stage as a one-cycle data_ok pulse. It serves both as the bring-up data-cache
// replacement and as the uncached-access path.
//
// Ports
//   clk, rst              : clock, synchronous active-high reset
//   flush                 : pipeline flush; kills the report of an in-flight op
//   valid, op             : request valid; op 0 = load, 1 = store
//   virtual_addr          : request address (identity-mapped to physical)
//   wdata, wstrb          : lane-aligned store data and byte enables
//   addr_ok               : request accepted this cycle (combinational)
//   data_ok, rdata        : completion pulse; load data valid with it
//   busy                  : a request is in flight
//   rd_req/rd_type/rd_addr/rd_rdy           : bus read request channel
//   ret_valid/ret_last/ret_data             : bus read return channel
//   wr_req/wr_type/wr_addr/wr_wstrb/wr_data/wr_rdy : bus posted write channel
// -----------------------------------------------------------------------------
module dcache_uncached_responder #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    valid,
    input  logic                    op,
    input  logic [ADDR_WIDTH-1:0]   virtual_addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    addr_ok,
    output logic                    data_ok,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    busy,
    output logic                    rd_req,
    output logic [2:0]              rd_type,
    output logic [ADDR_WIDTH-1:0]   rd_addr,
    input  logic                    rd_rdy,
    input  logic                    ret_valid,
    input  logic                    ret_last,
    input  logic [DATA_WIDTH-1:0]   ret_data,
    output logic                    wr_req,
    output logic [2:0]              wr_type,
    output logic [ADDR_WIDTH-1:0]   wr_addr,
    output logic [DATA_WIDTH/8-1:0] wr_wstrb,
    output logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    wr_rdy
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_REQ  = 3'd1;
    localparam logic [2:0] S_RD_WAIT = 3'd2;
    localparam logic [2:0] S_WR_REQ  = 3'd3;
    localparam logic [2:0] S_RESP    = 3'd4;

    localparam logic [2:0] XFER_WORD = 3'b010;

    logic [2:0]            state_q, state_d;
    logic                  op_q, op_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  kill_q, kill_d;

    // Byte offset is dropped on the bus; the mem stage does sub-word extraction.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = &{1'b0, virtual_addr[1:0]};

    assign addr_ok = (state_q == S_IDLE) && !flush && !rst;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        data_d  = data_q;
        kill_d  = kill_q;

        case (state_q)
            S_IDLE: begin
                if (valid && addr_ok) begin
                    op_d    = op;
                    addr_d  = {virtual_addr[ADDR_WIDTH-1:2], 2'b00};
                    wdata_d = wdata;
                    wstrb_d = wstrb;
                    kill_d  = 1'b0;
                    if (!op) begin
                        state_d = S_RD_REQ;
                    end else if (wstrb != '0) begin
                        state_d = S_WR_REQ;
                    end else begin
                        // All-lanes-disabled store has nothing to write.
                        state_d = S_RESP;
                    end
                end
            end
            S_RD_REQ: begin
                if (rd_rdy) begin
                    state_d = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                // Every beat overwrites the capture, so the final beat wins.
                if (ret_valid) begin
                    data_d = ret_data;
                    if (ret_last) begin
                        state_d = S_RESP;
                    end
                end
            end
            S_WR_REQ: begin
                if (wr_rdy) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                kill_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A flush while the bus transfer is running only hides the result;
        // the transfer itself always finishes so the bridge stays in sync.
        if (flush && (state_q != S_IDLE) && (state_q != S_RESP)) begin
            kill_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            data_q  <= '0;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            data_q  <= data_d;
            kill_q  <= kill_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign data_ok  = (state_q == S_RESP) && !kill_q && !flush;
    assign rdata    = ((state_q == S_RESP) && !op_q) ? data_q : '0;

    assign rd_req   = (state_q == S_RD_REQ);
    assign rd_type  = XFER_WORD;
    assign rd_addr  = addr_q;

    assign wr_req   = (state_q == S_WR_REQ);
    assign wr_type  = XFER_WORD;
    assign wr_addr  = addr_q;
    assign wr_wstrb = wstrb_q;
    assign wr_data  = wdata_q;

endmodule

// File: tb/tb_dcache_uncached_responder.sv
// -----------------------------------------------------------------------------
// Bench for dcache_uncached_responder: directed stimulus, a transaction-level
// model of the outstanding request checked against the DUT every cycle, plus
// literal expectations for latencies, addresses and data.
// -----------------------------------------------------------------------------
module tb_dcache_uncached_responder;

    logic        clk = 1'b0;
    logic        rst, flush, valid, op;
    logic [31:0] vaddr, wdata;
    logic [3:0]  wstrb;
    logic        addr_ok, data_ok, busy;
    logic [31:0] rdata;
    logic        rd_req, rd_rdy, ret_valid, ret_last;
    logic [2:0]  rd_type, wr_type;
    logic [31:0] rd_addr, ret_data;
    logic        wr_req, wr_rdy;
    logic [31:0] wr_addr, wr_data;
    logic [3:0]  wr_wstrb;

    always #5 clk = ~clk;

    dcache_uncached_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .valid(valid), .op(op),
        .virtual_addr(vaddr), .wdata(wdata), .wstrb(wstrb),
        .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata), .busy(busy),
        .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
        .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr),
        .wr_wstrb(wr_wstrb), .wr_data(wr_data), .wr_rdy(wr_rdy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // One outstanding request at most; progress tracked as "address phase
    // done" (m_sent) and "final beat returned" (m_back).
    logic        m_out = 0, m_load = 0, m_sent = 0, m_back = 0, m_killed = 0;
    logic [31:0] m_addr = 0, m_wdata = 0, m_data = 0;
    logic [3:0]  m_strb = 0;
    logic        m_done, e_rd_req, e_wr_req;
    logic        chk_en = 0;

    // Statistics from the DUT, used by the literal checks.
    int          cyc = 0, acc_cyc = 0, ok_cyc = 0;
    int          n_acc = 0, n_ok = 0, n_rdreq = 0, n_wrreq = 0;
    logic [31:0] ok_data = 0, seen_rd_addr = 0, seen_wr_addr = 0, seen_wr_data = 0;
    logic [3:0]  seen_wr_strb = 0;

    always @(negedge clk) begin
        cyc++;
        m_done   = m_out && (m_load ? m_back : ((m_strb == 4'h0) || m_sent));
        e_rd_req = m_out && m_load && !m_sent;
        e_wr_req = m_out && !m_load && (m_strb != 4'h0) && !m_sent;
        if (chk_en) begin
            check("addr_ok", addr_ok, !m_out && !flush && !rst);
            check("busy",    busy,    m_out);
            check("data_ok", data_ok, m_done && !m_killed && !flush);
            check("rd_req",  rd_req,  e_rd_req);
            check("wr_req",  wr_req,  e_wr_req);
            check("rd_type", rd_type, 3'b010);
            check("wr_type", wr_type, 3'b010);
            if (m_done)   check("rdata", rdata, m_load ? m_data : 32'h0);
            if (e_rd_req) check("rd_addr", rd_addr, m_addr);
            if (e_wr_req) begin
                check("wr_addr",  wr_addr,  m_addr);
                check("wr_wstrb", wr_wstrb, m_strb);
                check("wr_data",  wr_data,  m_wdata);
            end
            if (valid && addr_ok) begin acc_cyc = cyc; n_acc++; end
            if (data_ok) begin ok_cyc = cyc; ok_data = rdata; n_ok++; end
            if (rd_req) begin n_rdreq++; seen_rd_addr = rd_addr; end
            if (wr_req) begin
                n_wrreq++; seen_wr_addr = wr_addr;
                seen_wr_strb = wr_wstrb; seen_wr_data = wr_data;
            end
        end
        // advance the model with this cycle's inputs
        if (rst) begin
            m_out = 0; m_load = 0; m_sent = 0; m_back = 0; m_killed = 0;
            m_addr = 0; m_wdata = 0; m_strb = 0; m_data = 0;
        end else if (!m_out) begin
            if (valid && !flush) begin
                m_out = 1; m_load = !op; m_sent = 0; m_back = 0; m_killed = 0;
                m_addr = vaddr & 32'hffff_fffc; m_wdata = wdata; m_strb = wstrb;
            end
        end else if (m_done) begin
            m_out = 0;
        end else begin
            if (flush) m_killed = 1;
            if (m_load) begin
                if (!m_sent) begin
                    if (rd_rdy) m_sent = 1;
                end else if (ret_valid) begin
                    m_data = ret_data;
                    if (ret_last) m_back = 1;
                end
            end else if (wr_rdy) begin
                m_sent = 1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic sample;
        @(negedge clk); #2;
    endtask

    // Load with bus answering as fast as allowed; result checked literally.
    task automatic fast_load(input logic [31:0] a, input logic [31:0] d, input string tag);
        int rd0, ok0;
        rd0 = n_rdreq; ok0 = n_ok;
        tick; valid = 1; op = 0; vaddr = a;
        tick; valid = 0; rd_rdy = 1;
        tick; rd_rdy = 0; ret_valid = 1; ret_last = 1; ret_data = d;
        tick; ret_valid = 0; ret_last = 0;
        sample;
        check({tag, "_latency"}, ok_cyc - acc_cyc, 3);
        check({tag, "_rdata"},   ok_data, d);
        check({tag, "_rd_addr"}, seen_rd_addr, a & 32'hffff_fffc);
        check({tag, "_rd_reqs"}, n_rdreq - rd0, 1);
        check({tag, "_oks"},     n_ok - ok0, 1);
    endtask

    initial begin
        int s_acc, s_rd, s_ok, s_wr;
        rst = 1; flush = 0; valid = 0; op = 0; vaddr = 0; wdata = 0; wstrb = 0;
        rd_rdy = 0; ret_valid = 0; ret_last = 0; ret_data = 0; wr_rdy = 0;
        tick; tick;
        chk_en = 1;
        sample;
        check("rst_addr_ok", addr_ok, 0);
        check("rst_busy",    busy,    0);
        check("rst_data_ok", data_ok, 0);
        check("rst_rd_req",  rd_req,  0);
        check("rst_wr_req",  wr_req,  0);
        check("rst_rdata",   rdata,   0);
        tick; rst = 0;
        sample;
        check("idle_addr_ok", addr_ok, 1);

        // 1: basic load
        fast_load(32'h1c00_0104, 32'hdead_beef, "load1");

        // 2: store with bus stalling four cycles
        s_wr = n_wrreq; s_ok = n_ok;
        tick; valid = 1; op = 1; vaddr = 32'h0000_0013; wdata = 32'haa00_0000; wstrb = 4'b1000;
        tick; valid = 0;
        repeat (3) tick;
        tick; wr_rdy = 1;
        tick; wr_rdy = 0;
        sample;
        check("st_wr_cycles", n_wrreq - s_wr, 5);
        check("st_latency",   ok_cyc - acc_cyc, 6);
        check("st_wr_addr",   seen_wr_addr, 32'h0000_0010);
        check("st_wr_strb",   seen_wr_strb, 4'b1000);
        check("st_wr_data",   seen_wr_data, 32'haa00_0000);
        check("st_rdata",     ok_data, 0);
        check("st_oks",       n_ok - s_ok, 1);

        // 3: zero-strobe store
        s_wr = n_wrreq;
        tick; valid = 1; op = 1; vaddr = 32'h0000_2000; wdata = 32'h55; wstrb = 4'b0000;
        tick; valid = 0;
        sample;
        check("z_data_ok", data_ok, 1);
        check("z_addr_ok_resp", addr_ok, 0);
        tick;
        sample;
        check("z_addr_ok_idle", addr_ok, 1);
        check("z_busy", busy, 0);
        check("z_no_wr", n_wrreq - s_wr, 0);
        check("z_latency", ok_cyc - acc_cyc, 1);

        // 4: flush during RD_WAIT, then a normal load
        s_ok = n_ok;
        tick; valid = 1; op = 0; vaddr = 32'h1000_0008;
        tick; valid = 0; rd_rdy = 1;
        tick; rd_rdy = 0; flush = 1;
        sample;
        check("fl_busy_wait", busy, 1);
        tick; flush = 0; ret_valid = 1; ret_last = 1; ret_data = 32'h1234_5678;
        tick; ret_valid = 0; ret_last = 0;
        sample;
        check("fl_data_ok", data_ok, 0);
        check("fl_busy_resp", busy, 1);
        tick;
        sample;
        check("fl_busy_idle", busy, 0);
        check("fl_no_ok", n_ok - s_ok, 0);
        fast_load(32'h1000_000e, 32'hcafe_f00d, "load2");

        // 5: valid held high, back-to-back loads; then valid+flush in IDLE
        s_acc = n_acc; s_rd = n_rdreq; s_ok = n_ok;
        tick; valid = 1; op = 0; vaddr = 32'h3000_0000;
        rd_rdy = 1; ret_valid = 1; ret_last = 1; ret_data = 32'h0bad_cafe;
        repeat (15) tick;
        tick; flush = 1;
        sample;
        check("b2b_flush_addr_ok", addr_ok, 0);
        tick; flush = 0; valid = 0; rd_rdy = 0; ret_valid = 0; ret_last = 0;
        sample;
        check("b2b_accepts", n_acc - s_acc, 4);
        check("b2b_rd_reqs", n_rdreq - s_rd, 4);
        check("b2b_oks",     n_ok - s_ok, 4);
        check("b2b_rdata",   ok_data, 32'h0bad_cafe);

        // 6: reset while in WR_REQ
        s_ok = n_ok;
        tick; valid = 1; op = 1; vaddr = 32'h0000_0044; wdata = 32'h1; wstrb = 4'hf;
        tick; valid = 0;
        sample;
        check("rw_wr_req", wr_req, 1);
        tick; rst = 1;
        tick; rst = 0;
        sample;
        check("rw_wr_req_after", wr_req, 0);
        check("rw_busy_after",   busy, 0);
        check("rw_data_ok",      data_ok, 0);
        check("rw_addr_ok",      addr_ok, 1);
        tick;
        sample;
        check("rw_no_ok", n_ok - s_ok, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
